// File: rtl/vga_sync_monitor.sv
// VGA receive-side timing recovery: measures line/frame length, declares lock, regenerates x/y/de.
// Build option: define VGA_MON_LOCK_GATE_EN to force de/x/y/line_start/frame_start low while unlocked.
module vga_sync_monitor #(
    parameter int unsigned H_ACT_OFS  = 144,
    parameter int unsigned H_ACT      = 640,
    parameter int unsigned V_ACT_OFS  = 36,
    parameter int unsigned V_ACT      = 480,
    parameter int unsigned LOCK_LINES = 4,
    parameter int unsigned CW         = 12
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          pix_stb,
    input  logic          hs_n,
    input  logic          vs_n,
    output logic [9:0]    x,
    output logic [9:0]    y,
    output logic          de,
    output logic          line_start,
    output logic          frame_start,
    output logic          locked,
    output logic          sync_err,
    output logic [CW-1:0] h_total,
    output logic [CW-1:0] v_total
);
    localparam logic [CW-1:0] CNT_MAX   = '1;
    localparam int unsigned   SW        = $clog2(LOCK_LINES + 1);
    localparam logic [SW-1:0] STAB_FULL = SW'(LOCK_LINES);
    localparam logic [CW-1:0] H_LO      = CW'(H_ACT_OFS);
    localparam logic [CW-1:0] H_HI      = CW'(H_ACT_OFS + H_ACT);
    localparam logic [CW-1:0] V_LO      = CW'(V_ACT_OFS);
    localparam logic [CW-1:0] V_HI      = CW'(V_ACT_OFS + V_ACT);

    logic          r_hs_prev;
    logic          r_vs_prev;
    logic          r_h_ref;
    logic          r_v_ref;
    logic          r_v_stable;
    logic [CW-1:0] r_h_cnt;
    logic [CW-1:0] r_v_line;
    logic [SW-1:0] r_stab;

    logic          w_hs_edge;
    logic          w_vs_edge;
    logic          w_timeout;
    logic [CW-1:0] w_h_meas;
    logic [CW-1:0] w_h_cnt_nx;
    logic [CW-1:0] w_v_line_nx;
    logic [CW-1:0] w_h_total_nx;
    logic [CW-1:0] w_v_total_nx;
    logic [SW-1:0] w_stab_nx;
    logic          w_h_ref_nx;
    logic          w_v_ref_nx;
    logic          w_v_stable_nx;
    logic          w_locked_nx;
    logic          w_de_nx;
    logic          w_ls_nx;
    logic          w_fs_nx;
    logic [9:0]    w_x_nx;
    logic [9:0]    w_y_nx;

    // Next-state of the measurement, lock and coordinate logic for one pixel tick.
    always_comb begin
        w_hs_edge     = r_hs_prev & ~hs_n;
        w_vs_edge     = r_vs_prev & ~vs_n;
        w_h_meas      = r_h_cnt + CW'(1);
        w_timeout     = ~w_hs_edge && (r_h_cnt == CNT_MAX - CW'(1));
        w_h_cnt_nx    = r_h_cnt;
        w_h_ref_nx    = r_h_ref;
        w_stab_nx     = r_stab;
        w_h_total_nx  = h_total;
        w_v_line_nx   = r_v_line;
        w_v_ref_nx    = r_v_ref;
        w_v_total_nx  = v_total;
        w_v_stable_nx = r_v_stable;

        if (w_hs_edge) begin
            w_h_cnt_nx = '0;
            if (r_h_ref) begin
                w_h_total_nx = w_h_meas;
                if (w_h_meas == h_total)
                    w_stab_nx = (r_stab == STAB_FULL) ? STAB_FULL : r_stab + SW'(1);
                else
                    w_stab_nx = '0;
            end
            w_h_ref_nx = 1'b1;
        end else begin
            if (r_h_cnt != CNT_MAX)
                w_h_cnt_nx = r_h_cnt + CW'(1);
            if (w_timeout) begin
                w_h_ref_nx = 1'b0;
                w_stab_nx  = '0;
            end
        end

        // vs restarts the line count first so a coincident hs edge lands on line 1.
        if (w_vs_edge) begin
            if (r_v_ref) begin
                w_v_total_nx  = r_v_line;
                w_v_stable_nx = (r_v_line == v_total);
            end
            w_v_line_nx = '0;
            w_v_ref_nx  = 1'b1;
        end
        if (w_hs_edge && (w_v_line_nx != CNT_MAX))
            w_v_line_nx = w_v_line_nx + CW'(1);

        w_locked_nx = (w_stab_nx == STAB_FULL) && w_v_stable_nx;

        w_de_nx = w_h_ref_nx && w_v_ref_nx &&
                  (w_h_cnt_nx >= H_LO) && (w_h_cnt_nx < H_HI) &&
                  (w_v_line_nx >= V_LO) && (w_v_line_nx < V_HI);
`ifdef VGA_MON_LOCK_GATE_EN
        w_de_nx = w_de_nx && w_locked_nx;
`endif
        w_x_nx  = w_de_nx ? 10'(w_h_cnt_nx - H_LO) : 10'd0;
        w_y_nx  = w_de_nx ? 10'(w_v_line_nx - V_LO) : 10'd0;
        w_ls_nx = w_de_nx && (w_x_nx == 10'd0);
        w_fs_nx = w_ls_nx && (w_y_nx == 10'd0);
    end

    // State only advances on a pixel tick; pulses drop on the following clk.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hs_prev   <= 1'b0;
            r_vs_prev   <= 1'b0;
            r_h_ref     <= 1'b0;
            r_v_ref     <= 1'b0;
            r_v_stable  <= 1'b0;
            r_h_cnt     <= '0;
            r_v_line    <= '0;
            r_stab      <= '0;
            h_total     <= '0;
            v_total     <= '0;
            x           <= '0;
            y           <= '0;
            de          <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            locked      <= 1'b0;
            sync_err    <= 1'b0;
        end else if (pix_stb) begin
            r_hs_prev   <= hs_n;
            r_vs_prev   <= vs_n;
            r_h_ref     <= w_h_ref_nx;
            r_v_ref     <= w_v_ref_nx;
            r_v_stable  <= w_v_stable_nx;
            r_h_cnt     <= w_h_cnt_nx;
            r_v_line    <= w_v_line_nx;
            r_stab      <= w_stab_nx;
            h_total     <= w_h_total_nx;
            v_total     <= w_v_total_nx;
            x           <= w_x_nx;
            y           <= w_y_nx;
            de          <= w_de_nx;
            line_start  <= w_ls_nx;
            frame_start <= w_fs_nx;
            locked      <= w_locked_nx;
            sync_err    <= locked & ~w_locked_nx;
        end else begin
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            sync_err    <= 1'b0;
        end
    end
endmodule

// File: tb/tb_vga_sync_monitor.sv
// Self-checking bench for vga_sync_monitor: scaled-down VGA timing, random strobe gaps, event-level reference model.
module tb_vga_sync_monitor;
    localparam int H_OFS = 8;
    localparam int H_ACT = 24;
    localparam int V_OFS = 4;
    localparam int V_ACT = 20;
    localparam int LOCK  = 4;
    localparam int CW    = 10;
    localparam int H_TOT = 40;
    localparam int HS_W  = 4;
    localparam int V_TOT = 30;
    localparam int VS_W  = 2;
    localparam int MAXC  = (1 << CW) - 1;
    localparam int VW    = 25 + 2 * CW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          pix_stb = 1'b0;
    logic          hs_n = 1'b1;
    logic          vs_n = 1'b1;
    logic [9:0]    x;
    logic [9:0]    y;
    logic          de;
    logic          line_start;
    logic          frame_start;
    logic          locked;
    logic          sync_err;
    logic [CW-1:0] h_total;
    logic [CW-1:0] v_total;

    int checks = 0;
    int failures = 0;
    int ls_cnt = 0;
    int fs_cnt = 0;
    int err_cnt = 0;

    vga_sync_monitor #(
        .H_ACT_OFS(H_OFS), .H_ACT(H_ACT), .V_ACT_OFS(V_OFS), .V_ACT(V_ACT),
        .LOCK_LINES(LOCK), .CW(CW)
    ) dut (
        .clk(clk), .rst(rst), .pix_stb(pix_stb), .hs_n(hs_n), .vs_n(vs_n),
        .x(x), .y(y), .de(de), .line_start(line_start), .frame_start(frame_start),
        .locked(locked), .sync_err(sync_err), .h_total(h_total), .v_total(v_total)
    );

    always #5 clk = ~clk;

    // Counts every clk a pulse is seen, so a stretched pulse counts more than once.
    always @(negedge clk) begin
        if (line_start === 1'b1) ls_cnt++;
        if (frame_start === 1'b1) fs_cnt++;
        if (sync_err === 1'b1) err_cnt++;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference model: tick indices of edges, hs-edge counts and a history of line lengths.
    int   m_t, m_t_hs, m_lines, m_htot, m_vtot, m_x, m_y;
    logic m_href, m_vref, m_vstable, m_locked, m_err, m_hsp, m_vsp, m_de, m_ls, m_fs;
    int   hq[$];

    task automatic model_reset();
        m_t = 0; m_t_hs = 0; m_lines = 0; m_htot = 0; m_vtot = 0; m_x = 0; m_y = 0;
        m_href = 0; m_vref = 0; m_vstable = 0; m_locked = 0; m_err = 0;
        m_hsp = 0; m_vsp = 0; m_de = 0; m_ls = 0; m_fs = 0;
        hq.delete();
        hq.push_back(0);
    endtask

    task automatic model_step(input logic hs, input logic vs);
        logic he, ve, lockh, nl;
        int   pos;
        he = m_hsp && !hs;
        ve = m_vsp && !vs;
        m_hsp = hs;
        m_vsp = vs;
        m_t++;
        if (ve) begin
            if (m_vref) begin
                m_vstable = (m_lines == m_vtot);
                m_vtot = m_lines;
            end
            m_lines = 0;
            m_vref = 1;
        end
        if (he) begin
            if (m_lines < MAXC) m_lines++;
            if (m_href) begin
                m_htot = m_t - m_t_hs;
                hq.push_back(m_htot);
                if (hq.size() > LOCK + 1) void'(hq.pop_front());
            end
            m_t_hs = m_t;
            m_href = 1;
        end else if (m_t - m_t_hs == MAXC) begin
            m_href = 0;
            hq.delete();
            hq.push_back(m_htot);
        end
        lockh = (hq.size() == LOCK + 1);
        for (int i = 0; i < hq.size(); i++)
            if (hq[i] != hq[hq.size() - 1]) lockh = 0;
        nl = lockh && m_vstable;
        m_err = m_locked && !nl;
        m_locked = nl;
        pos = (m_t - m_t_hs > MAXC) ? MAXC : m_t - m_t_hs;
        m_de = m_href && m_vref && pos >= H_OFS && pos < H_OFS + H_ACT &&
               m_lines >= V_OFS && m_lines < V_OFS + V_ACT;
`ifdef VGA_MON_LOCK_GATE_EN
        m_de = m_de && m_locked;
`endif
        m_x = m_de ? pos - H_OFS : 0;
        m_y = m_de ? m_lines - V_OFS : 0;
        m_ls = m_de && (m_x == 0);
        m_fs = m_ls && (m_y == 0);
    endtask

    function automatic logic [VW-1:0] dut_vec();
        return {de, x, y, line_start, frame_start, locked, sync_err, h_total, v_total};
    endfunction

    function automatic logic [VW-1:0] mdl_vec();
        return {m_de, 10'(m_x), 10'(m_y), m_ls, m_fs, m_locked, m_err, CW'(m_htot), CW'(m_vtot)};
    endfunction

    // One pixel tick with a random 0..1 clk gap; returns at the negedge after sampling.
    task automatic tick(input logic hs, input logic vs);
        repeat ($urandom_range(0, 1)) @(negedge clk);
        @(negedge clk);
        hs_n = hs; vs_n = vs; pix_stb = 1'b1;
        @(negedge clk);
        pix_stb = 1'b0;
        model_step(hs, vs);
    endtask

    task automatic apply_reset(input logic hs_level);
        @(negedge clk);
        hs_n = hs_level; rst = 1'b1; pix_stb = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0; pix_stb = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        apply_reset(1'b1);
        checks++;
        if (dut_vec() !== '0) begin
            failures++; $display("FAIL reset_values got=%h exp=0", dut_vec());
        end
        repeat (6) @(negedge clk);
        checks++;
        if (dut_vec() !== '0) begin
            failures++; $display("FAIL no_strobe_hold got=%h exp=0", dut_vec());
        end
        tick(1'b1, 1'b1);
        tick(1'b1, 1'b1);
        checks++;
        if (dut_vec() !== mdl_vec()) begin
            failures++; $display("FAIL idle_ticks got=%h exp=%h", dut_vec(), mdl_vec());
        end
    endtask

    task automatic test_lock();
        int de_f0 = 0;
        for (int f = 0; f < 3; f++) begin
            for (int l = 0; l < V_TOT; l++) begin
                for (int p = 0; p < H_TOT; p++) begin
                    tick(p >= HS_W, l >= VS_W);
                    checks++;
                    if (dut_vec() !== mdl_vec()) begin
                        failures++;
                        $display("FAIL lock_track f=%0d l=%0d p=%0d got=%h exp=%h", f, l, p, dut_vec(), mdl_vec());
                    end
                    if (f == 0 && de === 1'b1) de_f0++;
                    if (l == 0 && p == 0) begin
                        checks++;
                        if (locked !== (f == 2)) begin
                            failures++; $display("FAIL lock_at_vs f=%0d got=%b exp=%b", f, locked, f == 2);
                        end
                    end
                end
            end
        end
        checks++;
`ifdef VGA_MON_LOCK_GATE_EN
        if (de_f0 !== 0) begin
            failures++; $display("FAIL prelock_de got=%0d exp=0", de_f0);
        end
`else
        if (de_f0 !== V_ACT * H_ACT) begin
            failures++; $display("FAIL prelock_de got=%0d exp=%0d", de_f0, V_ACT * H_ACT);
        end
`endif
        checks++;
        if (h_total !== CW'(H_TOT) || v_total !== CW'(V_TOT)) begin
            failures++; $display("FAIL totals got=%0d/%0d exp=%0d/%0d", h_total, v_total, H_TOT, V_TOT);
        end
    endtask

    task automatic test_coincident();
        int fs_at = -1;
        int de_n = 0;
        int xsum = 0;
        int ls0, fs0;
        repeat (2) @(negedge clk);
        ls0 = ls_cnt; fs0 = fs_cnt;
        for (int l = 0; l < V_TOT; l++) begin
            for (int p = 0; p < H_TOT; p++) begin
                tick(p >= HS_W, l >= VS_W);
                checks++;
                if (dut_vec() !== mdl_vec()) begin
                    failures++;
                    $display("FAIL frame_track l=%0d p=%0d got=%h exp=%h", l, p, dut_vec(), mdl_vec());
                end
                if (de === 1'b1) begin
                    de_n++;
                    xsum += int'(x);
                end
                if (frame_start === 1'b1 && fs_at < 0) begin
                    fs_at = l * H_TOT + p;
                    checks++;
                    if ({x, y} !== 20'd0) begin
                        failures++; $display("FAIL frame_start_xy got=%0d,%0d exp=0,0", x, y);
                    end
                end
            end
        end
        repeat (2) @(negedge clk);
        checks++;
        if (fs_at !== (V_OFS - 1) * H_TOT + H_OFS) begin
            failures++; $display("FAIL first_active_pos got=%0d exp=%0d", fs_at, (V_OFS - 1) * H_TOT + H_OFS);
        end
        checks++;
        if (de_n !== V_ACT * H_ACT || xsum !== V_ACT * (H_ACT * (H_ACT - 1) / 2)) begin
            failures++; $display("FAIL de_ticks got=%0d xsum=%0d exp=%0d xsum=%0d", de_n, xsum, V_ACT * H_ACT, V_ACT * (H_ACT * (H_ACT - 1) / 2));
        end
        checks++;
        if (ls_cnt - ls0 !== V_ACT || fs_cnt - fs0 !== 1) begin
            failures++; $display("FAIL pulse_counts got=%0d/%0d exp=%0d/1", ls_cnt - ls0, fs_cnt - fs0, V_ACT);
        end
    endtask

    task automatic test_short_line();
        int e0;
        repeat (2) @(negedge clk);
        e0 = err_cnt;
        for (int l = 0; l < V_TOT; l++) begin
            for (int p = 0; p < ((l == 10) ? H_TOT - 1 : H_TOT); p++) begin
                tick(p >= HS_W, l >= VS_W);
                checks++;
                if (dut_vec() !== mdl_vec()) begin
                    failures++;
                    $display("FAIL short_track l=%0d p=%0d got=%h exp=%h", l, p, dut_vec(), mdl_vec());
                end
                if ((l == 11 && p == 0) || (l == 15 && p == H_TOT - 1) || (l == 16 && p == 0)) begin
                    checks++;
                    if (locked !== (l == 16)) begin
                        failures++; $display("FAIL short_lock l=%0d p=%0d got=%b exp=%b", l, p, locked, l == 16);
                    end
                end
            end
        end
        repeat (2) @(negedge clk);
        checks++;
        if (err_cnt - e0 !== 1 || locked !== 1'b1 || h_total !== CW'(H_TOT)) begin
            failures++; $display("FAIL short_err got=%0d lock=%b ht=%0d exp=1 lock=1 ht=%0d", err_cnt - e0, locked, h_total, H_TOT);
        end
    endtask

    task automatic test_reset_midframe();
        int e0;
        for (int l = 0; l < 12; l++) begin
            for (int p = 0; p < H_TOT; p++) begin
                tick(p >= HS_W, l >= VS_W);
                checks++;
                if (dut_vec() !== mdl_vec()) begin
                    failures++;
                    $display("FAIL mid_track l=%0d p=%0d got=%h exp=%h", l, p, dut_vec(), mdl_vec());
                end
            end
        end
        repeat (2) @(negedge clk);
        e0 = err_cnt;
        checks++;
        if (locked !== 1'b1) begin
            failures++; $display("FAIL mid_locked got=%b exp=1", locked);
        end
        apply_reset(1'b0);
        checks++;
        if (dut_vec() !== '0) begin
            failures++; $display("FAIL mid_reset_values got=%h exp=0", dut_vec());
        end
        repeat (2) @(negedge clk);
        checks++;
        if (err_cnt !== e0) begin
            failures++; $display("FAIL mid_reset_err got=%0d exp=%0d", err_cnt - e0, 0);
        end
        for (int n = 0; n < 3; n++) begin
            for (int p = 0; p < H_TOT; p++) begin
                tick((n == 0) ? (p >= 3) : (p >= HS_W), 1'b1);
                checks++;
                if (dut_vec() !== mdl_vec()) begin
                    failures++;
                    $display("FAIL relock_track n=%0d p=%0d got=%h exp=%h", n, p, dut_vec(), mdl_vec());
                end
            end
            checks++;
            if (h_total !== ((n == 2) ? CW'(H_TOT) : CW'(0))) begin
                failures++; $display("FAIL post_reset_edge n=%0d got=%0d exp=%0d", n, h_total, (n == 2) ? H_TOT : 0);
            end
        end
    endtask

    task automatic test_timeout();
        int e0;
        int de_after = 0;
        int fall = MAXC - (H_TOT - 1);
        for (int f = 0; f < 4; f++) begin
            for (int l = 0; l < ((f == 3) ? 10 : V_TOT); l++) begin
                for (int p = 0; p < H_TOT; p++) begin
                    tick(p >= HS_W, l >= VS_W);
                    checks++;
                    if (dut_vec() !== mdl_vec()) begin
                        failures++;
                        $display("FAIL to_track f=%0d l=%0d p=%0d got=%h exp=%h", f, l, p, dut_vec(), mdl_vec());
                    end
                end
            end
        end
        repeat (2) @(negedge clk);
        e0 = err_cnt;
        checks++;
        if (locked !== 1'b1) begin
            failures++; $display("FAIL relocked got=%b exp=1", locked);
        end
        for (int i = 1; i <= fall + 10; i++) begin
            tick(1'b1, 1'b1);
            checks++;
            if (dut_vec() !== mdl_vec()) begin
                failures++;
                $display("FAIL hold_track i=%0d got=%h exp=%h", i, dut_vec(), mdl_vec());
            end
            if (i >= fall && de === 1'b1) de_after++;
            if (i == fall - 1 || i == fall) begin
                checks++;
                if (locked !== (i == fall - 1)) begin
                    failures++; $display("FAIL timeout_edge i=%0d got=%b exp=%b", i, locked, i == fall - 1);
                end
            end
        end
        repeat (2) @(negedge clk);
        checks++;
        if (err_cnt - e0 !== 1 || locked !== 1'b0 || de_after !== 0) begin
            failures++; $display("FAIL timeout got err=%0d lock=%b de=%0d exp err=1 lock=0 de=0", err_cnt - e0, locked, de_after);
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_lock();
        test_coincident();
        test_short_line();
        test_reset_midframe();
        test_timeout();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/vga_sync_monitor.md
# vga_sync_monitor

Receive-side VGA timing recovery. The block watches active-low `hs_n`/`vs_n` sync inputs sampled on a pixel strobe and measures line and frame length. It declares lock once the timing is stable, then regenerates pixel coordinates, a data-enable, and line/frame start pulses. It sits after the display timing generator or an external video source and drives capture, overlay or self-check logic in the DDR video path.

## Interface
- `H_ACT_OFS`, 144: pixel ticks from the hsync edge tick to the first active pixel
- `H_ACT`, 640: active pixels per line
- `V_ACT_OFS`, 36: line index (hs edges since vs edge) of the first active line
- `V_ACT`, 480: active lines per frame
- `LOCK_LINES`, 4: consecutive equal line measurements required for horizontal stability
- `CW`, 12: width of the tick/line counters and measurement outputs
- `clk` in 1: system clock
- `rst` in 1: reset, synchronous, active-high
- `pix_stb` in 1: one-clk pixel strobe; all sync sampling happens only when this is high
- `hs_n` in 1: horizontal sync, active low
- `vs_n` in 1: vertical sync, active low
- `x` out 10: active pixel column; 0 when `de`=0
- `y` out 10: active line; 0 when `de`=0
- `de` out 1: active pixel
- `line_start` out 1: one-clk pulse on the first active pixel of each active line
- `frame_start` out 1: one-clk pulse on pixel (0,0)
- `locked` out 1: timing stable
- `sync_err` out 1: one-clk pulse on loss of lock
- `h_total` out CW: ticks in the last complete line
- `v_total` out CW: hs edges in the last complete frame

## Operation
- Edge detection runs on each `pix_stb` tick. `hs_prev`/`vs_prev` hold the previous tick's sampled value. An edge is prev=1 and current=0.
- On an hs edge:
  - `h_cnt`←0.
  - If `h_ref` is set: `h_total`←`h_cnt`+1, and the stability counter increments, saturating at `LOCK_LINES`, when the new value equals the old `h_total`; otherwise it clears.
  - `h_ref`←1.
- Without an hs edge, `h_cnt` increments and saturates at 2^CW−1.
- Saturation of `h_cnt` is a timeout. It clears `h_ref`, the stability counter and `locked`.
- On a vs edge:
  - If `v_ref` is set: `v_total`←`v_line`, and `v_stable`←(new equals old `v_total`).
  - Then `v_line`←0 and `v_ref`←1.
  - An hs edge on the same tick is applied after, so `v_line`=1.
- `v_line` increments on every hs edge and saturates at 2^CW−1.
- `locked` = stability counter==`LOCK_LINES` and `v_stable`. Any mismatch clears it on the same tick.
- `sync_err` pulses when `locked` falls for any reason other than `rst`.
- `de` is high when `h_ref`, `v_ref`, `H_ACT_OFS`≤`h_cnt`<`H_ACT_OFS`+`H_ACT` and `V_ACT_OFS`≤`v_line`<`V_ACT_OFS`+`V_ACT`.
- `x`=`h_cnt`−`H_ACT_OFS` and `y`=`v_line`−`V_ACT_OFS`; both are 10-bit truncated.
- `line_start` = `de` and `x`==0. `frame_start` = `line_start` and `y`==0.

## Timing
- Reset values:
  - All counters, `h_total`, `v_total`, `x`, `y`, `de`, `line_start`, `frame_start`, `locked`, `sync_err`, `h_ref`, `v_ref`, `v_stable` are 0.
  - `hs_prev` and `vs_prev` are 0, so an input already low at reset is not an edge.
- `rst` overrides `pix_stb` on the same clk. Reset mid-frame drops lock with no `sync_err` pulse; the block relocks from fresh edges.
- All outputs are registered and update on the clk edge that samples a `pix_stb` tick. They hold between ticks.
- `line_start`, `frame_start` and `sync_err` are high for exactly one clk, never for the whole strobe period.
- Measurements use the counter values from before the edge. `h_total` and `v_total` are visible the clk after the edge tick.
- Minimum lock time from reset, with clean sync: three vs edges (reference, first measurement, equal second measurement).
- Without `pix_stb`, nothing changes. A missing strobe is not a timeout.

## Configuration
- `VGA_MON_LOCK_GATE_EN` defined: `de`, `x`, `y`, `line_start` and `frame_start` are forced to 0 while `locked`=0.
- Not defined: these outputs follow the counters whenever `h_ref` and `v_ref` are set, regardless of lock.
- Measurement and lock logic are identical either way.

## Test plan
- Sync pattern: `pix_stb` every 4 clk, lines of 800 ticks with `hs_n` low for 96, frames of 525 lines with `vs_n` low for 2 lines. Required: `h_total`=800, `v_total`=525, `locked` rises on the 3rd vs edge, exactly one `frame_start` per frame, 480 `line_start` pulses, 640 `de` ticks per active line, and `x` runs 0..639.
- Once locked, shorten one line to 799 ticks. Required: `locked`→0 and one `sync_err` pulse at that hs edge; relock after `LOCK_LINES` equal lines.
- Hold `hs_n` high for 4095 ticks. Required: timeout, `locked`=0, one `sync_err` pulse, and with `VGA_MON_LOCK_GATE_EN` defined `de` stays 0.
- vs and hs edges on the same tick. Required: `v_line`=1 after the tick and the first active line begins at `v_line`=36.
- Assert `rst` mid-frame while locked, with `hs_n` low during reset. Required: all outputs 0 with no `sync_err`, and no edge is detected until `hs_n` returns high then low.
- Build with and without `VGA_MON_LOCK_GATE_EN`. Required: before lock, `de` is 0 with the macro defined and toggles without it.
